// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache answering fetch with 1-cycle hits.
// Misses refill a whole aligned line from backing memory one beat per req/ack handshake.
module icache #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        read_enb,
    input  logic [31:0] read_addr,
    output logic [31:0] inst_out,
    output logic        inst_valid,
    output logic        busy,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REFILL,
        ST_RESPOND
    } state_t;

    state_t                 r_state;
    logic [NUM_LINES-1:0]   r_valid;
    logic [TAG_W-1:0]       r_tag  [NUM_LINES];
    logic [31:0]            r_data [NUM_LINES][LINE_WORDS];
    logic [IDX_W-1:0]       r_req_idx;
    logic [OFF_W-1:0]       r_req_off;
    logic [OFF_W-1:0]       r_beat;
    logic                   r_flush_pend;

    logic [OFF_W-1:0]       w_off;
    logic [IDX_W-1:0]       w_idx;
    logic [TAG_W-1:0]       w_tag;
    logic                   w_hit;
    logic                   w_miss;
    logic                   w_beat_done;

    assign w_off       = read_addr[OFF_W-1:0];
    assign w_idx       = read_addr[OFF_W+IDX_W-1:OFF_W];
    assign w_tag       = read_addr[31:OFF_W+IDX_W];
    assign w_hit       = (r_state == ST_IDLE) & read_enb & r_valid[w_idx]
                         & (r_tag[w_idx] == w_tag) & ~flush;
    assign w_miss      = (r_state == ST_IDLE) & read_enb & ~w_hit;
    assign w_beat_done = (r_state == ST_REFILL) & mem_req & mem_ack;
    assign busy        = (r_state != ST_IDLE) | (read_enb & ~w_hit);

    // Line storage carries no reset; the valid bits alone decide what is usable.
    always_ff @(posedge clk) begin
        if (rstn) begin
            if (w_miss) begin
                r_tag[w_idx] <= w_tag;
            end
            if (w_beat_done) begin
                r_data[r_req_idx][r_beat] <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_valid      <= '0;
            r_req_idx    <= '0;
            r_req_off    <= '0;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
            inst_out     <= 32'd0;
            inst_valid   <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    inst_valid <= 1'b0;
                    if (flush) begin
                        r_valid <= '0;
                    end
                    if (w_hit) begin
                        inst_out   <= r_data[w_idx][w_off];
                        inst_valid <= 1'b1;
                    end else if (read_enb) begin
                        // The victim line is invalidated now so a half-written line is never hit.
                        r_valid[w_idx] <= 1'b0;
                        r_req_idx      <= w_idx;
                        r_req_off      <= w_off;
                        r_beat         <= '0;
                        mem_addr       <= {read_addr[31:OFF_W], {OFF_W{1'b0}}};
                        mem_req        <= 1'b1;
                        r_state        <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    inst_valid <= 1'b0;
                    if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (w_beat_done) begin
                        r_beat   <= r_beat + 1'b1;
                        mem_addr <= mem_addr + 32'd1;
                        if (r_beat == OFF_W'(LINE_WORDS - 1)) begin
                            mem_req <= 1'b0;
                            r_state <= ST_RESPOND;
                        end
                    end
                end
                ST_RESPOND: begin
                    inst_out     <= r_data[r_req_idx][r_req_off];
                    inst_valid   <= 1'b1;
                    r_flush_pend <= 1'b0;
                    r_state      <= ST_IDLE;
                    if (r_flush_pend | flush) begin
                        r_valid <= '0;
                    end else begin
                        r_valid[r_req_idx] <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Randomized bench for icache: a line-residency model predicts hit/miss, data and refill timing,
// while a behavioural memory responder answers refill beats with a programmable ack delay.
module tb_icache;

    localparam int LW = 4;

    logic        clk;
    logic        rstn;
    logic        read_enb;
    logic [31:0] read_addr;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        busy;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    icache #(.LINE_WORDS(LW), .NUM_LINES(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .read_enb   (read_enb),
        .read_addr  (read_addr),
        .inst_out   (inst_out),
        .inst_valid (inst_valid),
        .busy       (busy),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: which line address (word address / LW) each slot currently holds.
    bit          m_res  [16];
    logic [29:0] m_line [16];

    function automatic bit m_hit(input logic [31:0] a);
        int slot;
        slot = (a / LW) % 16;
        return m_res[slot] && (m_line[slot] == 30'(a / LW));
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 + a;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 16; i++) m_res[i] = 1'b0;
    endtask

    // Memory responder: each beat is acknowledged after ack_lat idle cycles.
    int          ack_lat    = 0;
    int          wait_cnt   = 0;
    bit          chk_stable = 1'b1;
    logic [31:0] acked_q [$];
    logic        prev_req   = 1'b0;
    logic        prev_ack   = 1'b0;
    logic [31:0] prev_addr  = 32'd0;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
    end

    always @(negedge clk) begin
        if (chk_stable && prev_req && !prev_ack) begin
            check("req_held", {31'd0, mem_req}, 32'd1);
            check("addr_held", mem_addr, prev_addr);
        end
        if (mem_req) begin
            if (wait_cnt <= 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                acked_q.push_back(mem_addr);
                wait_cnt  = ack_lat;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = wait_cnt - 1;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = ack_lat;
        end
        prev_req  = mem_req;
        prev_ack  = mem_ack;
        prev_addr = mem_addr;
    end

    task automatic fetch(input logic [31:0] a, input bit flush_mid);
        bit          exp_hit;
        int          cyc;
        logic [31:0] base;
        @(negedge clk);
        read_enb  = 1'b1;
        read_addr = a;
        flush     = 1'b0;
        #1;
        exp_hit = m_hit(a);
        base    = a & ~32'(LW - 1);
        check("busy_on_req", {31'd0, busy}, exp_hit ? 32'd0 : 32'd1);
        if (exp_hit) begin
            @(posedge clk); #1;
            check("hit_valid", {31'd0, inst_valid}, 32'd1);
            check("hit_data", inst_out, mem_word(a));
            check("hit_no_req", {31'd0, mem_req}, 32'd0);
        end else begin
            acked_q.delete();
            @(posedge clk); #1;
            read_enb = 1'b0;
            check("miss_req", {31'd0, mem_req}, 32'd1);
            check("miss_base", mem_addr, base);
            check("miss_busy", {31'd0, busy}, 32'd1);
            cyc = 0;
            while (!inst_valid && cyc < 400) begin
                flush = (flush_mid && cyc == 2);
                @(posedge clk); #1;
                cyc++;
            end
            flush = 1'b0;
            check("miss_valid", {31'd0, inst_valid}, 32'd1);
            check("miss_data", inst_out, mem_word(a));
            check("miss_latency", cyc, LW * (ack_lat + 1) + 1);
            check("busy_after", {31'd0, busy}, 32'd0);
            check("beat_count", acked_q.size(), LW);
            for (int k = 0; k < acked_q.size() && k < LW; k++)
                check("beat_addr", acked_q[k], base + k);
            if (flush_mid) begin
                m_clear();
            end else begin
                m_res[(a / LW) % 16]  = 1'b1;
                m_line[(a / LW) % 16] = 30'(a / LW);
            end
        end
    endtask

    task automatic do_flush();
        @(negedge clk);
        read_enb = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        m_clear();
    endtask

    logic [25:0] tag_pool [4];

    initial begin
        int          cyc;
        logic [31:0] a;
        rstn      = 1'b0;
        read_enb  = 1'b0;
        read_addr = 32'd0;
        flush     = 1'b0;
        m_clear();
        tag_pool[0] = 26'd0;
        tag_pool[1] = 26'd1;
        tag_pool[2] = 26'd3;
        tag_pool[3] = 26'h2AB_CDE;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_out", inst_out, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed: cold miss, hits, conflict eviction, slow memory, flushes.
        fetch(32'h5, 1'b0);
        fetch(32'h6, 1'b0);
        fetch(32'h7, 1'b0);
        fetch(32'h45, 1'b0);
        fetch(32'h5, 1'b0);
        ack_lat = 3;
        fetch(32'h109, 1'b0);
        ack_lat = 0;
        fetch(32'h5, 1'b0);
        do_flush();
        fetch(32'h5, 1'b0);
        fetch(32'h85, 1'b1);
        fetch(32'h85, 1'b0);

        // Reset in the middle of a refill.
        ack_lat    = 1;
        chk_stable = 1'b0;
        acked_q.delete();
        @(negedge clk);
        read_enb  = 1'b1;
        read_addr = 32'h5;
        @(posedge clk); #1;
        read_enb = 1'b0;
        cyc = 0;
        while (acked_q.size() < 2 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_mid_reached", {31'd0, acked_q.size() >= 2}, 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_out", inst_out, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        m_clear();
        @(negedge clk);
        chk_stable = 1'b1;
        ack_lat    = 0;
        fetch(32'h5, 1'b0);

        // Random traffic over a few tags so hits, conflicts and flushes mix.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                do_flush();
            end else begin
                ack_lat = $urandom_range(0, 2);
                a = {tag_pool[$urandom_range(0, 3)], 6'($urandom_range(0, 63))};
                fetch(a, $urandom_range(0, 9) == 0);
            end
        end

        @(negedge clk);
        read_enb = 1'b0;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
